// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory read, holds the fetched word for decode, handles redirects.
// Optional debug ports (dbg_state, dbg_fetch_count) are built when FETCH_DEBUG_EN is defined.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter logic [31:0] PC_STEP  = 32'h1
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ready,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
`ifdef FETCH_DEBUG_EN
   output logic [31:0] pc,
   output logic [1:0]  dbg_state,
   output logic [31:0] dbg_fetch_count
`else
   output logic [31:0] pc
`endif
);

   typedef enum logic [1:0] {
      ST_REQ   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t state;

   assign mem_req     = (state == ST_REQ);
   assign mem_addr    = pc;
   assign instr_valid = (state == ST_HOLD);

   // DRAIN swallows the one response still in flight for a PC that a redirect made stale.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_REQ;
         pc       <= RESET_PC;
         instr    <= 32'h0;
         instr_pc <= 32'h0;
      end else begin
         case (state)
            ST_REQ: begin
               if (redirect) begin
                  pc    <= redirect_pc;
                  state <= mem_ready ? ST_DRAIN : ST_REQ;
               end else if (mem_ready) begin
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (redirect) begin
                  pc    <= redirect_pc;
                  state <= ST_DRAIN;
               end else if (mem_rvalid) begin
                  instr    <= mem_rdata;
                  instr_pc <= pc;
                  pc       <= pc + PC_STEP;
                  state    <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (redirect) begin
                  pc    <= redirect_pc;
                  state <= ST_REQ;
               end else if (instr_ready) begin
                  state <= ST_REQ;
               end
            end
            ST_DRAIN: begin
               if (redirect) begin
                  pc <= redirect_pc;
               end
               if (mem_rvalid) begin
                  state <= ST_REQ;
               end
            end
            default: state <= ST_REQ;
         endcase
      end
   end

`ifdef FETCH_DEBUG_EN
   assign dbg_state = state;

   // Only instructions actually handed to decode count; a redirect in the same cycle discards the word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dbg_fetch_count <= 32'h0;
      end else if (instr_valid && instr_ready && !redirect) begin
         dbg_fetch_count <= dbg_fetch_count + 32'h1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with a scoreboard of expected {instr, instr_pc}.
module tb_fetch_unit;
   localparam logic [31:0] RESET_PC = 32'h0;
   localparam logic [31:0] PC_STEP  = 32'h1;

   typedef struct packed {
      logic [31:0] data;
      logic [31:0] addr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ready = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = 32'h0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic [31:0] pc;
`ifdef FETCH_DEBUG_EN
   logic [1:0]  dbg_state;
   logic [31:0] dbg_fetch_count;
`endif

   exp_t        exp_q[$];
   logic [31:0] exp_pc;
   int          passed = 0;
   int          total = 0;

   fetch_unit #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) dut (
      .clk(clk), .rst(rst),
      .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
      .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
`ifdef FETCH_DEBUG_EN
      .pc(pc), .dbg_state(dbg_state), .dbg_fetch_count(dbg_fetch_count)
`else
      .pc(pc)
`endif
   );

   always #5 clk = ~clk;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Accept a request and return data one cycle later; leaves the DUT holding the word.
   task automatic do_fetch(input logic [31:0] data);
      mem_ready = 1'b1;
      cycle();
      mem_ready  = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = data;
      exp_q.push_back('{data: data, addr: exp_pc});
      exp_pc = exp_pc + PC_STEP;
      cycle();
      mem_rvalid = 1'b0;
   endtask

   task automatic consume();
      instr_ready = 1'b1;
      cycle();
      instr_ready = 1'b0;
   endtask

   task automatic test_reset();
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      total++; if (pc !== RESET_PC) $display("[TB] FAIL reset_pc: got %h expected %h", pc, RESET_PC); else passed++;
      total++; if (instr_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", instr_valid); else passed++;
      total++; if (instr !== 32'h0) $display("[TB] FAIL reset_instr: got %h expected 0", instr); else passed++;
      total++; if (instr_pc !== 32'h0) $display("[TB] FAIL reset_instr_pc: got %h expected 0", instr_pc); else passed++;
      cycle();
      rst = 1'b0;
      exp_pc = RESET_PC;
      exp_q.delete();
      cycle();
      total++; if (mem_req !== 1'b1) $display("[TB] FAIL reset_mem_req: got %b expected 1", mem_req); else passed++;
      total++; if (mem_addr !== RESET_PC) $display("[TB] FAIL reset_mem_addr: got %h expected %h", mem_addr, RESET_PC); else passed++;
   endtask

   task automatic test_basic_fetch();
      exp_t e;
      total++; if (mem_addr !== exp_pc) $display("[TB] FAIL basic_addr0: got %h expected %h", mem_addr, exp_pc); else passed++;
      mem_ready = 1'b1;
      cycle();
      mem_ready = 1'b0;
      total++; if (mem_req !== 1'b0) $display("[TB] FAIL basic_wait_req: got %b expected 0", mem_req); else passed++;
      total++; if (instr_valid !== 1'b0) $display("[TB] FAIL basic_wait_valid: got %b expected 0", instr_valid); else passed++;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEADBEEF;
      exp_q.push_back('{data: 32'hDEADBEEF, addr: exp_pc});
      exp_pc = exp_pc + PC_STEP;
      cycle();
      mem_rvalid = 1'b0;
      total++; if (instr_valid !== 1'b1) $display("[TB] FAIL basic_valid: got %b expected 1", instr_valid); else passed++;
      e = exp_q.pop_front();
      total++; if (instr !== e.data) $display("[TB] FAIL basic_instr: got %h expected %h", instr, e.data); else passed++;
      total++; if (instr_pc !== e.addr) $display("[TB] FAIL basic_instr_pc: got %h expected %h", instr_pc, e.addr); else passed++;
      consume();
      total++; if (mem_req !== 1'b1) $display("[TB] FAIL basic_next_req: got %b expected 1", mem_req); else passed++;
      total++; if (mem_addr !== 32'h1) $display("[TB] FAIL basic_next_addr: got %h expected 1", mem_addr); else passed++;
   endtask

   task automatic test_hold_stall();
      exp_t e;
      do_fetch(32'hCAFE0001);
      e = exp_q.pop_front();
      for (int i = 0; i < 5; i++) begin
         cycle();
         total++; if (instr_valid !== 1'b1) $display("[TB] FAIL stall_valid[%0d]: got %b expected 1", i, instr_valid); else passed++;
         total++; if (instr !== e.data) $display("[TB] FAIL stall_instr[%0d]: got %h expected %h", i, instr, e.data); else passed++;
         total++; if (mem_req !== 1'b0) $display("[TB] FAIL stall_req[%0d]: got %b expected 0", i, mem_req); else passed++;
      end
      total++; if (instr_pc !== e.addr) $display("[TB] FAIL stall_instr_pc: got %h expected %h", instr_pc, e.addr); else passed++;
      consume();
   endtask

   task automatic test_back_to_back();
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         total++; if (mem_addr !== exp_pc) $display("[TB] FAIL b2b_addr[%0d]: got %h expected %h", i, mem_addr, exp_pc); else passed++;
         do_fetch(32'h10000000 + 32'(i * 7));
         e = exp_q.pop_front();
         total++; if (instr_valid !== 1'b1) $display("[TB] FAIL b2b_valid[%0d]: got %b expected 1", i, instr_valid); else passed++;
         total++; if (instr !== e.data) $display("[TB] FAIL b2b_instr[%0d]: got %h expected %h", i, instr, e.data); else passed++;
         total++; if (instr_pc !== e.addr) $display("[TB] FAIL b2b_instr_pc[%0d]: got %h expected %h", i, instr_pc, e.addr); else passed++;
         consume();
      end
   endtask

   task automatic test_ignore_rvalid();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hBADBAD00;
      cycle();
      mem_rvalid = 1'b0;
      total++; if (mem_req !== 1'b1) $display("[TB] FAIL stray_req: got %b expected 1", mem_req); else passed++;
      total++; if (instr_valid !== 1'b0) $display("[TB] FAIL stray_valid: got %b expected 0", instr_valid); else passed++;
      total++; if (mem_addr !== exp_pc) $display("[TB] FAIL stray_addr: got %h expected %h", mem_addr, exp_pc); else passed++;
   endtask

   task automatic test_redirect_wait();
      mem_ready = 1'b1;
      cycle();
      mem_ready   = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 32'h40;
      cycle();
      redirect = 1'b0;
      exp_pc   = 32'h40;
      total++; if (mem_req !== 1'b0) $display("[TB] FAIL rdw_drain_req: got %b expected 0", mem_req); else passed++;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h1111;
      cycle();
      mem_rvalid = 1'b0;
      total++; if (instr_valid !== 1'b0) $display("[TB] FAIL rdw_valid: got %b expected 0", instr_valid); else passed++;
      total++; if (mem_addr !== 32'h40) $display("[TB] FAIL rdw_addr: got %h expected 40", mem_addr); else passed++;
      total++; if (mem_req !== 1'b1) $display("[TB] FAIL rdw_req: got %b expected 1", mem_req); else passed++;
   endtask

   task automatic test_redirect_wait_rvalid();
      mem_ready = 1'b1;
      cycle();
      mem_ready   = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 32'h80;
      mem_rvalid  = 1'b1;
      mem_rdata   = 32'h2222;
      cycle();
      redirect   = 1'b0;
      mem_rvalid = 1'b0;
      exp_pc     = 32'h80;
      total++; if (instr_valid !== 1'b0) $display("[TB] FAIL rdwr_valid: got %b expected 0", instr_valid); else passed++;
      total++; if (mem_req !== 1'b0) $display("[TB] FAIL rdwr_drain_req: got %b expected 0", mem_req); else passed++;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h3333;
      cycle();
      mem_rvalid = 1'b0;
      total++; if (instr_valid !== 1'b0) $display("[TB] FAIL rdwr_valid2: got %b expected 0", instr_valid); else passed++;
      total++; if (mem_addr !== 32'h80) $display("[TB] FAIL rdwr_addr: got %h expected 80", mem_addr); else passed++;
   endtask

   task automatic test_redirect_req_accept();
      mem_ready   = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h200;
      cycle();
      mem_ready = 1'b0;
      redirect  = 1'b0;
      exp_pc    = 32'h200;
      total++; if (mem_req !== 1'b0) $display("[TB] FAIL rdra_drain_req: got %b expected 0", mem_req); else passed++;
      total++; if (pc !== 32'h200) $display("[TB] FAIL rdra_pc: got %h expected 200", pc); else passed++;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h4444;
      cycle();
      mem_rvalid = 1'b0;
      total++; if (instr_valid !== 1'b0) $display("[TB] FAIL rdra_valid: got %b expected 0", instr_valid); else passed++;
      total++; if (mem_req !== 1'b1) $display("[TB] FAIL rdra_req: got %b expected 1", mem_req); else passed++;
   endtask

   task automatic test_redirect_hold_priority();
      exp_t e;
      total++; if (mem_addr !== exp_pc) $display("[TB] FAIL rdh_addr0: got %h expected %h", mem_addr, exp_pc); else passed++;
      do_fetch(32'h5555AAAA);
      e = exp_q.pop_front();
      total++; if (instr !== e.data) $display("[TB] FAIL rdh_instr: got %h expected %h", instr, e.data); else passed++;
      instr_ready = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      cycle();
      instr_ready = 1'b0;
      redirect    = 1'b0;
      exp_pc      = 32'h100;
      total++; if (instr_valid !== 1'b0) $display("[TB] FAIL rdh_valid: got %b expected 0", instr_valid); else passed++;
      total++; if (mem_addr !== 32'h100) $display("[TB] FAIL rdh_addr: got %h expected 100", mem_addr); else passed++;
      total++; if (mem_req !== 1'b1) $display("[TB] FAIL rdh_req: got %b expected 1", mem_req); else passed++;
   endtask

   task automatic test_wrap();
      exp_t e;
      redirect    = 1'b1;
      redirect_pc = 32'hFFFFFFFF;
      cycle();
      redirect = 1'b0;
      exp_pc   = 32'hFFFFFFFF;
      total++; if (mem_addr !== 32'hFFFFFFFF) $display("[TB] FAIL wrap_addr0: got %h expected ffffffff", mem_addr); else passed++;
      do_fetch(32'hA5A5A5A5);
      e = exp_q.pop_front();
      total++; if (instr_pc !== e.addr) $display("[TB] FAIL wrap_instr_pc: got %h expected %h", instr_pc, e.addr); else passed++;
      total++; if (instr !== e.data) $display("[TB] FAIL wrap_instr: got %h expected %h", instr, e.data); else passed++;
      consume();
      total++; if (mem_addr !== 32'h0) $display("[TB] FAIL wrap_next_addr: got %h expected 0", mem_addr); else passed++;
   endtask

   task automatic test_reset_mid_wait();
      redirect    = 1'b1;
      redirect_pc = 32'h300;
      cycle();
      redirect  = 1'b0;
      mem_ready = 1'b1;
      cycle();
      mem_ready = 1'b0;
      total++; if (mem_req !== 1'b0) $display("[TB] FAIL rstw_in_wait: got %b expected 0", mem_req); else passed++;
      #2;
      rst = 1'b1;
      #1;
      total++; if (pc !== RESET_PC) $display("[TB] FAIL rstw_pc_async: got %h expected %h", pc, RESET_PC); else passed++;
      cycle();
      rst        = 1'b0;
      exp_pc     = RESET_PC;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h77777777;
      cycle();
      mem_rvalid = 1'b0;
      total++; if (instr_valid !== 1'b0) $display("[TB] FAIL rstw_valid: got %b expected 0", instr_valid); else passed++;
      total++; if (pc !== RESET_PC) $display("[TB] FAIL rstw_pc: got %h expected %h", pc, RESET_PC); else passed++;
      total++; if (mem_req !== 1'b1) $display("[TB] FAIL rstw_req: got %b expected 1", mem_req); else passed++;
   endtask

`ifdef FETCH_DEBUG_EN
   task automatic test_debug();
      exp_t e;
      total++; if (dbg_fetch_count !== 32'h0) $display("[TB] FAIL dbg_count0: got %0d expected 0", dbg_fetch_count); else passed++;
      total++; if (dbg_state !== 2'd0) $display("[TB] FAIL dbg_state_req: got %0d expected 0", dbg_state); else passed++;
      for (int i = 0; i < 3; i++) begin
         do_fetch(32'h90000000 + 32'(i));
         e = exp_q.pop_front();
         total++; if (dbg_state !== 2'd2) $display("[TB] FAIL dbg_state_hold[%0d]: got %0d expected 2", i, dbg_state); else passed++;
         consume();
      end
      do_fetch(32'h9000FFFF);
      e = exp_q.pop_front();
      instr_ready = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h500;
      cycle();
      instr_ready = 1'b0;
      redirect    = 1'b0;
      exp_pc      = 32'h500;
      total++; if (dbg_fetch_count !== 32'd3) $display("[TB] FAIL dbg_count: got %0d expected 3", dbg_fetch_count); else passed++;
   endtask
`endif

   initial begin
      exp_pc = RESET_PC;
      test_reset();
      test_basic_fetch();
      test_hold_stall();
      test_back_to_back();
      test_ignore_rvalid();
      test_redirect_wait();
      test_redirect_wait_rvalid();
      test_redirect_req_accept();
      test_redirect_hold_priority();
      test_wrap();
      test_reset_mid_wait();
`ifdef FETCH_DEBUG_EN
      test_debug();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
